// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: ALU and load unit share one register-file write port, with a pending-write scoreboard.
// Optional same-cycle bypass of the registered write is enabled by defining RF_WB_BYPASS_EN.
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        byp1_hit,
  output logic        byp2_hit,
  output logic [31:0] byp1_data,
  output logic [31:0] byp2_data
`endif
);

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_e;

  ptr_e        r_ptr;
  ptr_e        w_ptrNext;
  logic        w_grantA;
  logic        w_grantB;
  logic        w_grant;
  logic [4:0]  w_wrRd;
  logic [31:0] w_wrData;
  logic [31:0] w_clrMask;
  logic [31:0] w_setMask;
  logic [31:0] w_busyNext;
  logic        r_we;
  logic [4:0]  r_rd;
  logic [31:0] r_wdata;
  logic [31:0] r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= PTR_A;
    end else begin
      r_ptr <= w_ptrNext;
    end
  end

  // Grants are suppressed during reset; the pointer only moves when both sides competed.
  always_comb begin
    w_grantA  = 1'b0;
    w_grantB  = 1'b0;
    w_ptrNext = r_ptr;
    if (!rst) begin
      if (a_valid && b_valid) begin
        if (r_ptr == PTR_A) begin
          w_grantA  = 1'b1;
          w_ptrNext = PTR_B;
        end else begin
          w_grantB  = 1'b1;
          w_ptrNext = PTR_A;
        end
      end else if (a_valid) begin
        w_grantA = 1'b1;
      end else if (b_valid) begin
        w_grantB = 1'b1;
      end
    end
  end

  assign w_grant  = w_grantA | w_grantB;
  assign w_wrRd   = w_grantB ? b_rd : a_rd;
  assign w_wrData = w_grantB ? b_data : a_data;
  assign a_ready  = w_grantA;
  assign b_ready  = w_grantB;

  // Issue-side set is applied after the writeback clear so a re-issued rd stays pending.
  assign w_clrMask  = w_grant ? (32'd1 << w_wrRd) : 32'd0;
  assign w_setMask  = iss_valid ? (32'd1 << iss_rd) : 32'd0;
  assign w_busyNext = ((r_busy & ~w_clrMask) | w_setMask) & 32'hFFFF_FFFE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_rd    <= 5'd0;
      r_wdata <= 32'd0;
      r_busy  <= 32'd0;
    end else begin
      r_we   <= w_grant && (w_wrRd != 5'd0);
      r_busy <= w_busyNext;
      if (w_grant) begin
        r_rd    <= w_wrRd;
        r_wdata <= w_wrData;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_rd    = r_rd;
  assign rf_wdata = r_wdata;
  assign busy     = r_busy;

`ifdef RF_WB_BYPASS_EN
  assign byp1_hit  = r_we && (r_rd == rs1) && (rs1 != 5'd0);
  assign byp2_hit  = r_we && (r_rd == rs2) && (rs2 != 5'd0);
  assign byp1_data = r_wdata;
  assign byp2_data = r_wdata;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table, reset sequences and a randomized run
// against a request-level reference model.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, iss_valid;
  logic [4:0]  a_rd, b_rd, iss_rd;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata, busy;
`ifdef RF_WB_BYPASS_EN
  logic [4:0]  rs1, rs2;
  logic        byp1_hit, byp2_hit;
  logic [31:0] byp1_data, byp2_data;
`endif

  int nChecks = 0;
  int nFails  = 0;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy)
`ifdef RF_WB_BYPASS_EN
    , .rs1(rs1), .rs2(rs2), .byp1_hit(byp1_hit), .byp2_hit(byp2_hit),
    .byp1_data(byp1_data), .byp2_data(byp2_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bd;
    logic        iv;
    logic [4:0]  ird;
    logic        exA;
    logic        exB;
    logic        exWe;
    logic        chkData;
    logic [4:0]  exRd;
    logic [31:0] exData;
    logic [31:0] exBusy;
  } vec_t;

  vec_t vecs[12];

  // Reference model state: who wins the next tie, pending-register set, and the write port.
  logic        mPreferB;
  logic [31:0] mPending;
  logic        mWe;
  logic [4:0]  mRd;
  logic [31:0] mData;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                               input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                               input logic iv, input logic [4:0] ird);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    iss_valid = iv; iss_rd = ird;
  endtask

  task automatic modelReset();
    mPreferB = 1'b0;
    mPending = 32'd0;
    mWe      = 1'b0;
    mRd      = 5'd0;
    mData    = 32'd0;
  endtask

  task automatic modelGrant(input logic av, input logic bv, output logic ga, output logic gb);
    if (av && bv) begin
      ga = !mPreferB;
      gb = mPreferB;
    end else begin
      ga = av;
      gb = bv && !av;
    end
  endtask

  task automatic modelEdge(input logic ga, input logic gb);
    logic [4:0]  rd;
    logic [31:0] data;
    rd   = gb ? b_rd : a_rd;
    data = gb ? b_data : a_data;
    if (a_valid && b_valid) mPreferB = ga;
    if (ga || gb) begin
      mWe   = (rd != 5'd0);
      mRd   = rd;
      mData = data;
      mPending[rd] = 1'b0;
    end else begin
      mWe = 1'b0;
    end
    if (iss_valid && iss_rd != 5'd0) mPending[iss_rd] = 1'b1;
    mPending[0] = 1'b0;
  endtask

  initial begin
    logic        ga, gb;
    logic        aPend, bPend;
    logic [4:0]  aRdR, bRdR;
    logic [31:0] aDataR, bDataR;

    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 32'h0000_0000};
    vecs[1]  = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd2, 32'h22, 1'b1, 5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 5'd1,  32'h11,       32'h0000_0080};
    vecs[2]  = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd2, 32'h22, 1'b1, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd2,  32'h22,       32'h0000_0080};
    vecs[3]  = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd2, 32'h22, 1'b1, 5'd2,  1'b1, 1'b0, 1'b1, 1'b1, 5'd1,  32'h11,       32'h0000_0084};
    vecs[4]  = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd2, 32'h22, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd2,  32'h22,       32'h0000_0080};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b1, 5'd2,  32'h22,       32'h0000_0080};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h99, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0000_0080};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 32'hB7, 1'b1, 5'd7,  1'b0, 1'b1, 1'b1, 1'b1, 5'd7,  32'hB7,       32'h0000_0080};
    vecs[8]  = '{1'b1, 5'd7,  32'h33,       1'b1, 5'd4, 32'h44, 1'b1, 5'd4,  1'b1, 1'b0, 1'b1, 1'b1, 5'd7,  32'h33,       32'h0000_0010};
    vecs[9]  = '{1'b1, 5'd7,  32'h33,       1'b1, 5'd4, 32'h44, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd4,  32'h44,       32'h0000_0000};
    vecs[10] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,  1'b1, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 32'h8000_0000};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 32'h8000_0000};

`ifdef RF_WB_BYPASS_EN
    rs1 = 5'd0;
    rs2 = 5'd0;
`endif

    // Reset held with a pending ALU request: nothing may be granted or written.
    rst = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'hCAFE0003, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_a_ready", 32'(a_ready), 32'd0);
    checkOutput("reset_b_ready", 32'(b_ready), 32'd0);
    checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
    checkOutput("reset_rf_rd", 32'(rf_rd), 32'd0);
    checkOutput("reset_rf_wdata", rf_wdata, 32'd0);
    checkOutput("reset_busy", busy, 32'd0);
    rst = 1'b0;
    iss_valid = 1'b0;
    #1;
    checkOutput("release_a_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(posedge clk);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].bv, vecs[i].brd, vecs[i].bd,
                    vecs[i].iv, vecs[i].ird);
      #1;
      checkOutput($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].exA));
      checkOutput($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].exB));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].exWe));
      if (vecs[i].chkData) begin
        checkOutput($sformatf("vec%0d_rf_rd", i), 32'(rf_rd), 32'(vecs[i].exRd));
        checkOutput($sformatf("vec%0d_rf_wdata", i), rf_wdata, vecs[i].exData);
      end
      checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].exBusy);
    end

    // Mid-operation reset: ALU wins a tie (pointer moves to B), then reset drops the write.
    @(negedge clk);
    applyStimulus(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b1, 5'd6);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_rf_we", 32'(rf_we), 32'd0);
    checkOutput("midrst_rf_rd", 32'(rf_rd), 32'd0);
    checkOutput("midrst_rf_wdata", rf_wdata, 32'd0);
    checkOutput("midrst_busy", busy, 32'd0);
    checkOutput("midrst_a_ready", 32'(a_ready), 32'd0);
    checkOutput("midrst_b_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    iss_valid = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("midrst_ptr_a_ready", 32'(a_ready), 32'd1);
    checkOutput("midrst_ptr_b_ready", 32'(b_ready), 32'd0);

    // Randomized run from a clean reset against the request-level model.
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    modelReset();
    aPend = 1'b0; bPend = 1'b0;
    aRdR = 5'd0; bRdR = 5'd0; aDataR = 32'd0; bDataR = 32'd0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!aPend && ($urandom_range(0, 2) != 0)) begin
        aPend  = 1'b1;
        aRdR   = 5'($urandom_range(0, 9));
        aDataR = $urandom;
      end
      if (!bPend && ($urandom_range(0, 2) != 0)) begin
        bPend  = 1'b1;
        bRdR   = 5'($urandom_range(0, 9));
        bDataR = $urandom;
      end
      applyStimulus(aPend, aRdR, aDataR, bPend, bRdR, bDataR,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)));
`ifdef RF_WB_BYPASS_EN
      rs1 = 5'($urandom_range(0, 9));
      rs2 = 5'($urandom_range(0, 9));
`endif
      #1;
      modelGrant(a_valid, b_valid, ga, gb);
      checkOutput("rand_a_ready", 32'(a_ready), 32'(ga));
      checkOutput("rand_b_ready", 32'(b_ready), 32'(gb));
      @(posedge clk);
      modelEdge(ga, gb);
      #1;
      checkOutput("rand_rf_we", 32'(rf_we), 32'(mWe));
      if (mWe) begin
        checkOutput("rand_rf_rd", 32'(rf_rd), 32'(mRd));
        checkOutput("rand_rf_wdata", rf_wdata, mData);
      end
      checkOutput("rand_busy", busy, mPending);
`ifdef RF_WB_BYPASS_EN
      checkOutput("rand_byp1_hit", 32'(byp1_hit), 32'(mWe && (mRd == rs1) && (rs1 != 5'd0)));
      checkOutput("rand_byp2_hit", 32'(byp2_hit), 32'(mWe && (mRd == rs2) && (rs2 != 5'd0)));
      if (mWe) begin
        checkOutput("rand_byp1_data", byp1_data, mData);
        checkOutput("rand_byp2_data", byp2_data, mData);
      end
`endif
      if (ga) aPend = 1'b0;
      if (gb) bPend = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
